// File: rtl/accel_bus_pkg.sv
// accel_bus_pkg -- shared definitions for the accelerator-side memory bus.
//
// Contents:
//   BUS_ADDR_W / BUS_DATA_W : default byte-address and data widths for bus ports
//   req_id_t                : 1-bit requester identifier (r0 / r1)
//   arb_state_t             : arbiter grant state (open for arbitration / locked)
//   other_req()             : the requester that is not the one given
package accel_bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;

  typedef logic req_id_t;

  localparam req_id_t REQ_ID_R0 = 1'b0;
  localparam req_id_t REQ_ID_R1 = 1'b1;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/rd_tag_fifo.sv
// rd_tag_fifo -- in-order FIFO of requester IDs for outstanding reads.
//
// Ports:
//   clk, rst_n : rising-edge clock, synchronous active-low reset (empties FIFO)
//   push       : record push_id (ignored while full)
//   push_id    : requester ID of the accepted read
//   pop        : drop the head entry (ignored while empty)
//   head_id    : requester ID at the head (oldest outstanding read)
//   full/empty : occupancy flags, derived from the registered pointers only
module rd_tag_fifo
  import accel_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output req_id_t head_id,
  output logic    full,
  output logic    empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] PTR_INC = {{IDX_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] slot_q, slot_d;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign head_id = slot_q[rd_ptr_q[IDX_W-1:0]];

  // Next pointer and storage values for push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    slot_d   = slot_q;
    if (push && !full) begin
      slot_d[wr_ptr_q[IDX_W-1:0]] = push_id;
      wr_ptr_d = wr_ptr_q + PTR_INC;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_INC;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {(IDX_W+1){1'b0}};
      rd_ptr_q <= {(IDX_W+1){1'b0}};
      slot_q   <= {DEPTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      slot_q   <= slot_d;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter -- two-port Avalon-MM arbiter in front of an SDRAM controller.
//
// Commands from r0/r1 are arbitrated round-robin and the winner is forwarded
// combinationally to mem_*. A stalled command locks the grant until accepted.
// Accepted reads record their requester in rd_tag_fifo so pipelined returns
// (in issue order) are routed back to the right port.
//
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   rN_address/read/write/
//   rN_writedata               : requester N command
//   rN_waitrequest             : 1 unless rN's command is accepted this cycle
//   rN_readdata/readdatavalid  : read return (data shared, valid per requester)
//   mem_address/read/write/
//   mem_writedata              : forwarded command to the SDRAM controller
//   mem_waitrequest            : controller stall
//   mem_readdata/readdatavalid : controller read return
//   err                        : sticky; a return arrived with no read outstanding
module sdram_port_arbiter
  import accel_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = BUS_ADDR_W,
  parameter int unsigned DATA_W = BUS_DATA_W,
  parameter int unsigned MAX_RD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [DATA_W-1:0] r0_writedata,
  output logic              r0_waitrequest,
  output logic [DATA_W-1:0] r0_readdata,
  output logic              r0_readdatavalid,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [DATA_W-1:0] r1_writedata,
  output logic              r1_waitrequest,
  output logic [DATA_W-1:0] r1_readdata,
  output logic              r1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_readdatavalid,
  output logic              err
);

  arb_state_t state_q, state_d;
  req_id_t    lock_id_q, lock_id_d;
  req_id_t    prio_q, prio_d;
  logic       err_q, err_d;

  logic       elig0_s, elig1_s;
  logic       gnt_valid_s;
  req_id_t    gnt_id_s;
  logic       sel_write_s;
  logic       accept_s;
  logic       fifo_full_s, fifo_empty_s;
  req_id_t    fifo_head_s;
  logic       ret_valid_s;

  // A write wins over a simultaneous read, so only pure reads are held off
  // by a full tag FIFO; that lets a writer take the grant instead.
  assign elig0_s = r0_write | (r0_read & ~fifo_full_s);
  assign elig1_s = r1_write | (r1_read & ~fifo_full_s);

  // Grant selection, acceptance, lock and priority-pointer next state.
  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    prio_d      = prio_q;
    gnt_valid_s = 1'b0;
    gnt_id_s    = REQ_ID_R0;
    case (state_q)
      ARB_LOCKED: begin
        gnt_id_s    = lock_id_q;
        gnt_valid_s = (lock_id_q == REQ_ID_R1) ? elig1_s : elig0_s;
      end
      ARB_OPEN: begin
        if (elig0_s && elig1_s) begin
          gnt_valid_s = 1'b1;
          gnt_id_s    = prio_q;
        end else if (elig0_s) begin
          gnt_valid_s = 1'b1;
          gnt_id_s    = REQ_ID_R0;
        end else if (elig1_s) begin
          gnt_valid_s = 1'b1;
          gnt_id_s    = REQ_ID_R1;
        end else begin
          gnt_valid_s = 1'b0;
          gnt_id_s    = REQ_ID_R0;
        end
      end
      default: begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = REQ_ID_R0;
      end
    endcase

    accept_s = gnt_valid_s & ~mem_waitrequest;

    if (accept_s) begin
      state_d = ARB_OPEN;
      prio_d  = other_req(gnt_id_s);
    end else if (gnt_valid_s) begin
      // Command stalled: keep it on the bus unchanged until accepted.
      state_d   = ARB_LOCKED;
      lock_id_d = gnt_id_s;
    end else begin
      state_d = ARB_OPEN;
    end
  end

  // Forward the granted requester's command.
  assign sel_write_s   = (gnt_id_s == REQ_ID_R1) ? r1_write : r0_write;
  assign mem_address   = (gnt_id_s == REQ_ID_R1) ? r1_address : r0_address;
  assign mem_writedata = (gnt_id_s == REQ_ID_R1) ? r1_writedata : r0_writedata;
  assign mem_write     = gnt_valid_s & sel_write_s;
  assign mem_read      = gnt_valid_s & ~sel_write_s;

  assign r0_waitrequest = ~(accept_s && (gnt_id_s == REQ_ID_R0));
  assign r1_waitrequest = ~(accept_s && (gnt_id_s == REQ_ID_R1));

  // A return with nothing outstanding is not routed anywhere.
  assign ret_valid_s      = mem_readdatavalid & ~fifo_empty_s;
  assign r0_readdata      = mem_readdata;
  assign r1_readdata      = mem_readdata;
  assign r0_readdatavalid = ret_valid_s & (fifo_head_s == REQ_ID_R0);
  assign r1_readdatavalid = ret_valid_s & (fifo_head_s == REQ_ID_R1);

  // Sticky error on an orphan return.
  always_comb begin
    err_d = err_q;
    if (mem_readdatavalid && fifo_empty_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end
  assign err = err_q;

  rd_tag_fifo #(
    .DEPTH (MAX_RD)
  ) u_rd_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept_s & mem_read),
    .push_id (gnt_id_s),
    .pop     (mem_readdatavalid),
    .head_id (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Arbiter state registers; reset favours r0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_OPEN;
      lock_id_q <= REQ_ID_R0;
      prio_q    <= REQ_ID_R0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      prio_q    <= prio_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: inputs change 1 time unit after a
// rising edge and outputs are sampled 1 time unit later.
module tb_sdram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] r0_address, r1_address;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [31:0] r0_writedata, r1_writedata;
  logic        r0_waitrequest, r1_waitrequest;
  logic [31:0] r0_readdata, r1_readdata;
  logic        r0_readdatavalid, r1_readdatavalid;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic        err;

  int n_cmp;
  int n_bad;

  sdram_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .MAX_RD (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .r0_address        (r0_address),
    .r0_read           (r0_read),
    .r0_write          (r0_write),
    .r0_writedata      (r0_writedata),
    .r0_waitrequest    (r0_waitrequest),
    .r0_readdata       (r0_readdata),
    .r0_readdatavalid  (r0_readdatavalid),
    .r1_address        (r1_address),
    .r1_read           (r1_read),
    .r1_write          (r1_write),
    .r1_writedata      (r1_writedata),
    .r1_waitrequest    (r1_waitrequest),
    .r1_readdata       (r1_readdata),
    .r1_readdatavalid  (r1_readdatavalid),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // Forwarded command and both waitrequests; address only checked when a command is expected.
  task automatic chk_bus(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic w0, input logic w1);
    chk1({tag, ".mem_read"}, mem_read, rd);
    chk1({tag, ".mem_write"}, mem_write, wr);
    if (rd || wr) chk({tag, ".mem_address"}, mem_address, addr);
    chk1({tag, ".r0_waitrequest"}, r0_waitrequest, w0);
    chk1({tag, ".r1_waitrequest"}, r1_waitrequest, w1);
  endtask

  // Return routing plus data pass-through to both ports.
  task automatic chk_ret(input string tag, input logic v0, input logic v1, input logic [31:0] data);
    chk1({tag, ".r0_readdatavalid"}, r0_readdatavalid, v0);
    chk1({tag, ".r1_readdatavalid"}, r1_readdatavalid, v1);
    chk({tag, ".r0_readdata"}, r0_readdata, data);
    chk({tag, ".r1_readdata"}, r1_readdata, data);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    r0_address = 32'h0; r0_read = 1'b0; r0_write = 1'b0; r0_writedata = 32'h0;
    r1_address = 32'h0; r1_read = 1'b0; r1_write = 1'b0; r1_writedata = 32'h0;
    mem_waitrequest = 1'b0; mem_readdata = 32'h0; mem_readdatavalid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk_bus("rst", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk_ret("rst", 1'b0, 1'b0, 32'h0);
    chk1("rst.err", err, 1'b0);

    // Both reading: r0,r1,r0,r1 then FIFO full blocks both
    adv();
    r0_read = 1'b1; r0_address = 32'h10;
    r1_read = 1'b1; r1_address = 32'h20;
    #1 chk_bus("rr0", 1'b1, 1'b0, 32'h10, 1'b0, 1'b1);
    adv(); #1 chk_bus("rr1", 1'b1, 1'b0, 32'h20, 1'b1, 1'b0);
    adv(); #1 chk_bus("rr2", 1'b1, 1'b0, 32'h10, 1'b0, 1'b1);
    adv(); #1 chk_bus("rr3", 1'b1, 1'b0, 32'h20, 1'b1, 1'b0);
    adv(); #1 chk_bus("rr_full", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    r0_read = 1'b0; r1_read = 1'b0;
    mem_readdatavalid = 1'b1; mem_readdata = 32'hA0;
    #1 chk_ret("ret0", 1'b1, 1'b0, 32'hA0);
    adv(); mem_readdata = 32'hA1; #1 chk_ret("ret1", 1'b0, 1'b1, 32'hA1);
    adv(); mem_readdata = 32'hA2; #1 chk_ret("ret2", 1'b1, 1'b0, 32'hA2);
    adv(); mem_readdata = 32'hA3; #1 chk_ret("ret3", 1'b0, 1'b1, 32'hA3);
    adv(); mem_readdatavalid = 1'b0;
    #1 chk1("rr.err", err, 1'b0);

    // r0 write stalled 3 cycles while r1 reads
    adv();
    r0_write = 1'b1; r0_address = 32'h100; r0_writedata = 32'hDEADBEEF;
    r1_read = 1'b1; r1_address = 32'h200; mem_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk_bus("wstall", 1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
      chk("wstall.wdata", mem_writedata, 32'hDEADBEEF);
      adv();
    end
    mem_waitrequest = 1'b0;
    #1 chk_bus("wacc", 1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
    chk("wacc.wdata", mem_writedata, 32'hDEADBEEF);
    adv(); r0_write = 1'b0;
    #1 chk_bus("r1gnt", 1'b1, 1'b0, 32'h200, 1'b1, 1'b0);
    adv(); r1_read = 1'b0; mem_readdatavalid = 1'b1; mem_readdata = 32'hB0;
    #1 chk_ret("bret", 1'b0, 1'b1, 32'hB0);
    adv(); mem_readdatavalid = 1'b0;

    // Lock holds r1 even though the pointer favours r0
    r1_write = 1'b1; r1_address = 32'h300; r1_writedata = 32'h11; mem_waitrequest = 1'b1;
    #1 chk_bus("lk0", 1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
    adv(); r0_write = 1'b1; r0_address = 32'h400; r0_writedata = 32'h22;
    #1 chk_bus("lk1", 1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
    chk("lk1.wdata", mem_writedata, 32'h11);
    adv(); mem_waitrequest = 1'b0;
    #1 chk_bus("lk2", 1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
    adv(); r1_write = 1'b0;
    #1 chk_bus("lk3", 1'b0, 1'b1, 32'h400, 1'b0, 1'b1);
    chk("lk3.wdata", mem_writedata, 32'h22);
    adv(); r0_write = 1'b0;

    // r1 fills the FIFO, 5th read stalls, r0 write passes, return unblocks next cycle
    r1_read = 1'b1; r1_address = 32'h600;
    for (int i = 0; i < 4; i++) begin
      #1 chk_bus("c_rd", 1'b1, 1'b0, 32'h600, 1'b1, 1'b0);
      adv();
    end
    r0_write = 1'b1; r0_address = 32'h500;
    #1 chk_bus("c_wr", 1'b0, 1'b1, 32'h500, 1'b0, 1'b1);
    adv(); r0_write = 1'b0; mem_readdatavalid = 1'b1; mem_readdata = 32'hC0;
    #1 chk_bus("c_pop", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk_ret("c_pop", 1'b0, 1'b1, 32'hC0);
    adv(); mem_readdatavalid = 1'b0;
    #1 chk_bus("c_unblk", 1'b1, 1'b0, 32'h600, 1'b1, 1'b0);
    adv(); r1_read = 1'b0;

    // Occupancy 3 with simultaneous return and accept
    mem_readdatavalid = 1'b1; mem_readdata = 32'hD0;
    #1 chk_ret("d_drain", 1'b0, 1'b1, 32'hD0);
    adv(); r0_read = 1'b1; r0_address = 32'h700; mem_readdata = 32'hD1;
    #1 chk_bus("d_same", 1'b1, 1'b0, 32'h700, 1'b0, 1'b1);
    chk_ret("d_same", 1'b0, 1'b1, 32'hD1);
    adv(); mem_readdatavalid = 1'b0;
    #1 chk_bus("d_fill", 1'b1, 1'b0, 32'h700, 1'b0, 1'b1);
    adv(); #1 chk_bus("d_full", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    adv(); r0_read = 1'b0; mem_readdatavalid = 1'b1; mem_readdata = 32'hE0;
    #1 chk_ret("d_ret0", 1'b0, 1'b1, 32'hE0);
    adv(); mem_readdata = 32'hE1; #1 chk_ret("d_ret1", 1'b0, 1'b1, 32'hE1);
    adv(); mem_readdata = 32'hE2; #1 chk_ret("d_ret2", 1'b1, 1'b0, 32'hE2);
    adv(); mem_readdata = 32'hE3; #1 chk_ret("d_ret3", 1'b1, 1'b0, 32'hE3);
    adv(); mem_readdatavalid = 1'b0;
    #1 chk1("d.err", err, 1'b0);

    // Reset with 2 reads outstanding; stale returns set err
    adv(); r0_read = 1'b1; r0_address = 32'h800;
    #1 chk_bus("e_rd0", 1'b1, 1'b0, 32'h800, 1'b0, 1'b1);
    adv(); #1 chk_bus("e_rd1", 1'b1, 1'b0, 32'h800, 1'b0, 1'b1);
    adv(); r0_read = 1'b0; rst_n = 1'b0;
    adv(); rst_n = 1'b1;
    #1 chk_bus("e_rst", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk1("e_rst.err", err, 1'b0);
    mem_readdatavalid = 1'b1; mem_readdata = 32'hF0;
    #1 chk_ret("e_stale0", 1'b0, 1'b0, 32'hF0);
    chk1("e_stale0.err", err, 1'b0);
    adv(); mem_readdata = 32'hF1;
    #1 chk_ret("e_stale1", 1'b0, 1'b0, 32'hF1);
    chk1("e_stale1.err", err, 1'b1);
    adv(); mem_readdatavalid = 1'b0;
    adv(); adv();
    #1 chk1("e_sticky.err", err, 1'b1);
    r1_write = 1'b1; r1_address = 32'h900;
    #1 chk_bus("e_wr", 1'b0, 1'b1, 32'h900, 1'b1, 1'b0);
    adv(); r1_write = 1'b0;
    #1 chk1("e_traffic.err", err, 1'b1);
    rst_n = 1'b0;
    adv(); rst_n = 1'b1;
    #1 chk1("e_clr.err", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte address width on all ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width on all ports.
REQ-003 SHALL have parameter MAX_RD, default 4, meaning maximum outstanding reads (power of 2, 2..16).
REQ-004 SHALL have port clk  in  1  meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  in  1  meaning reset, synchronous, active-low.
REQ-006 SHALL have ports r0_address/r1_address  in  ADDR_W  meaning requester command address.
REQ-007 SHALL have ports r0_read/r1_read  in  1  meaning requester read command.
REQ-008 SHALL have ports r0_write/r1_write  in  1  meaning requester write command.
REQ-009 SHALL have ports r0_writedata/r1_writedata  in  DATA_W  meaning requester write data.
REQ-010 SHALL have ports r0_waitrequest/r1_waitrequest  out  1  meaning command not accepted this cycle.
REQ-011 SHALL have ports r0_readdata/r1_readdata  out  DATA_W  meaning read data, driven from mem_readdata to both.
REQ-012 SHALL have ports r0_readdatavalid/r1_readdatavalid  out  1  meaning read data belongs to this requester.
REQ-013 SHALL have ports mem_address  out  ADDR_W, mem_read  out  1, mem_write  out  1 and mem_writedata  out  DATA_W, meaning the forwarded Avalon-MM command to the SDRAM controller.
REQ-014 SHALL have port mem_waitrequest  in  1  meaning the SDRAM controller stalls the command.
REQ-015 SHALL have ports mem_readdata  in  DATA_W and mem_readdatavalid  in  1, meaning pipelined read return in issue order.
REQ-016 SHALL have port err  out  1  meaning sticky flag: read data returned with no outstanding read recorded.

Function
REQ-017 SHALL treat requester N as requesting when rN_read|rN_write is high; read and write both high is illegal and handled as write.
REQ-018 SHALL grant round-robin: when both request and no lock, grant the requester not granted most recently; a single requester is granted immediately.
REQ-019 SHALL forward only the granted requester's command combinationally to mem_* (zero added latency); when none is granted, mem_read=mem_write=0.
REQ-020 SHALL accept a command in a cycle when it is granted, forwarded, and mem_waitrequest=0; the priority pointer updates on acceptance only.
REQ-021 SHALL set a lock when a forwarded command sees mem_waitrequest=1 and hold the grant on that requester until acceptance, as Avalon requires a stable command.
REQ-022 SHALL drive rN_waitrequest=1 whenever rN is not accepted that cycle, including when idle and not requesting.
REQ-023 SHALL record the requester ID (1 bit) of each accepted read in an in-order tag FIFO of depth MAX_RD.
REQ-024 SHALL block read commands (not forwarded, waitrequest=1, grant may pass to a writer) while the tag FIFO is full; a pop in the same cycle does not unblock.
REQ-025 SHALL on mem_readdatavalid=1 pop the FIFO head and assert rN_readdatavalid for the head ID in the same cycle; push and pop in one cycle keep occupancy constant.
REQ-026 SHALL, on mem_readdatavalid=1 with empty FIFO, assert no rN_readdatavalid and set err on the next edge.
REQ-027 SHALL forward writes regardless of FIFO occupancy; writes produce no return.

Reset
REQ-028 SHALL on rst_n=0 at a clock edge: clear lock, pointer favours r0, empty the FIFO, err=0; all outputs valid in the following cycle with mem_read=mem_write=0 only while no requester is asserting.
REQ-029 SHALL discard outstanding read tags on reset mid-operation; subsequently returned stale data sets err per REQ-026.
REQ-030 SHALL not clear err except by reset.

Structure
REQ-031 SHALL take ADDR_W/DATA_W defaults and a requester ID typedef from the shared package accel_bus_pkg.
REQ-032 SHALL implement the tag FIFO as sub-module rd_tag_fifo (1-bit data, depth MAX_RD, full/empty, registered pointers).

Verification
REQ-033 Both reading, mem_waitrequest=0 -> accepted order r0,r1,r0,r1; returns route to r0,r1,r0,r1.
REQ-034 r0 write 0x100/0xDEADBEEF, mem_waitrequest high 3 cycles, r1 reads meanwhile -> mem_* hold 0x100 write 4 cycles, r1 waits, then r1 granted.
REQ-035 r1 issues 4 reads with no return -> 5th read stalled; r0 write still accepted; one return unblocks reads next cycle.
REQ-036 Return and new accept in same cycle at occupancy 3 -> occupancy stays 3, correct readdatavalid routing.
REQ-037 Reset with 2 reads outstanding, then 2 mem_readdatavalid pulses -> no rN_readdatavalid, err=1 and stays 1.
